// File: rtl/sevga_pkg.sv
// sevga_pkg: shared constants, the queued write-entry type and the capture
// FSM state encoding for the CPU write queue.
package sevga_pkg;

    // Framebuffer window inside the 64 KB video page, in word offsets.
    localparam logic [13:0] FB_OFS_LO    = 14'h1380;
    localparam logic [13:0] FB_OFS_HI    = 14'h3E40;

    // Word address of the VIA port-A output register (byte address $EFFFFE).
    localparam logic [22:0] VIA_ORA_ADDR = 23'h77FFFF;

    // One byte-wide VRAM write waiting for the scheduler.
    typedef struct packed {
        logic        via;
        logic        bufSel;
        logic [14:0] addr;
        logic [7:0]  data;
    } wrq_entry_t;

    // Capture FSM states.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECIDE   = 3'd1,
        CAP_U    = 3'd2,
        CAP_L    = 3'd3,
        WAIT_END = 3'd4
    } cap_state_t;

    // True when the current bus cycle is a CPU write into the visible framebuffer.
    function automatic logic fb_hit(input logic [23:1] addr,
                                    input logic [2:0]  ram_size,
                                    input logic        rnw);
        return (addr[23:22] == 2'b00) &&
               (addr[21:19] == ram_size) &&
               (addr[18:16] == 3'b111) &&
               (addr[14:1] >= FB_OFS_LO) &&
               (addr[14:1] < FB_OFS_HI) &&
               !rnw;
    endfunction

endpackage

// File: rtl/cpu_write_queue_if.sv
// cpu_write_queue_if: drain port between the write queue and the VRAM scheduler.
//
// Handshake: the queue drives wrValid together with a head entry
// (wrBufSel/wrAddr/wrData/wrVia). The entry transfers on a rising pixClk edge
// where wrValid and wrAck are both high. While wrValid is high the head entry
// stays stable until it is acked; wrAck while wrValid is low has no effect.
interface cpu_write_queue_if;
    logic        wrValid;
    logic        wrAck;
    logic        wrBufSel;
    logic [14:0] wrAddr;
    logic [7:0]  wrData;
    logic        wrVia;

    modport master (
        output wrValid, wrBufSel, wrAddr, wrData, wrVia,
        input  wrAck
    );

    modport slave (
        input  wrValid, wrBufSel, wrAddr, wrData, wrVia,
        output wrAck
    );
endinterface

// File: rtl/sevga_sync_fifo.sv
// sevga_sync_fifo: synchronous FIFO of wrq_entry_t. A pushed entry becomes
// visible at the head one edge after the push; there is no bypass path.
// Push and pop in the same cycle both take effect. The head reads as zero
// while the FIFO is empty.
module sevga_sync_fifo
    import sevga_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             pixClk,
    input  logic             nReset,
    input  logic             i_push,
    input  wrq_entry_t       i_data,
    input  logic             i_pop,
    output wrq_entry_t       o_head,
    output logic             o_valid,
    output logic [LVL_W-1:0] o_level
);

    localparam int PTR_W = $clog2(DEPTH);

    wrq_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && (r_level != '0);

    // Storage write; contents need no reset because occupancy gates the head.
    always_ff @(posedge pixClk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping, flushed asynchronously by reset.
    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

    assign o_valid = (r_level != '0);
    assign o_head  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level = r_level;

endmodule

// File: rtl/cpu_write_queue.sv
// cpu_write_queue: captures 68000 framebuffer writes from the Mac SE bus into a
// pixClk-domain FIFO of byte-wide VRAM write entries drained by the scheduler.
// Optional feature macro: SEVGA_VIA_CAPTURE_EN -- when defined, UDS writes to
// the VIA ORA register are queued as a single entry with wrVia=1.
module cpu_write_queue
    import sevga_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                nReset,
    input  logic                pixClk,
    input  logic [23:1]         cpuAddr,
    input  logic [15:0]         cpuData,
    input  logic                ncpuAS,
    input  logic                ncpuUDS,
    input  logic                ncpuLDS,
    input  logic                cpuRnW,
    input  logic [2:0]          ramSize,
    cpu_write_queue_if.master   wr,
    output logic [LVL_W-1:0]    level,
    output logic                overflow,
    output cap_state_t          o_dbg_state
);

    // Strobe synchronizers (two flops each).
    logic             r_as_meta,  r_as_sync;
    logic             r_uds_meta, r_uds_sync;
    logic             r_lds_meta, r_lds_sync;

    // Capture FSM and per-cycle decisions.
    cap_state_t       r_state;
    cap_state_t       w_state_nxt;
    logic             r_want_l;
    logic             r_is_via;
    logic             r_overflow;

    logic             w_as;
    logic             w_uds;
    logic             w_lds;
    logic [13:0]      w_off;
    logic             w_fb_hit;
    logic             w_via_hit;
    logic [LVL_W-1:0] w_need;
    logic [LVL_W-1:0] w_free;
    logic             w_room;
    logic             w_set_ovf;

    wrq_entry_t       w_entry_u;
    wrq_entry_t       w_entry_l;
    wrq_entry_t       w_push_entry;
    logic             w_push;

    // FIFO side.
    wrq_entry_t       w_head;
    logic             w_valid;
    logic             w_pop;
    logic [LVL_W-1:0] w_level;

    // Synchronize the raw strobes. AS resets to "asserted" so that a bus cycle
    // already running at reset release is seen as in progress and skipped.
    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            r_as_meta  <= 1'b0;
            r_as_sync  <= 1'b0;
            r_uds_meta <= 1'b1;
            r_uds_sync <= 1'b1;
            r_lds_meta <= 1'b1;
            r_lds_sync <= 1'b1;
        end else begin
            r_as_meta  <= ncpuAS;
            r_as_sync  <= r_as_meta;
            r_uds_meta <= ncpuUDS;
            r_uds_sync <= r_uds_meta;
            r_lds_meta <= ncpuLDS;
            r_lds_sync <= r_lds_meta;
        end
    end

    assign w_as  = !r_as_sync;
    assign w_uds = !r_uds_sync;
    assign w_lds = !r_lds_sync;

    // Address decode; address, data and RnW are stable while DS is asserted.
    assign w_off    = cpuAddr[14:1] - FB_OFS_LO;
    assign w_fb_hit = fb_hit(cpuAddr, ramSize, cpuRnW) && (w_uds || w_lds);

`ifdef SEVGA_VIA_CAPTURE_EN
    assign w_via_hit = (cpuAddr == VIA_ORA_ADDR) && !cpuRnW && w_uds;
`else
    assign w_via_hit = 1'b0;
`endif

    // Bytes this bus cycle needs versus slots free at the registered level.
    always_comb begin
        w_need = '0;
        if (w_via_hit) begin
            w_need = LVL_W'(1);
        end else begin
            w_need = LVL_W'(w_uds) + LVL_W'(w_lds);
        end
    end

    assign w_free = LVL_W'(DEPTH) - w_level;
    assign w_room = (w_free >= w_need);

    // Candidate entries for the upper and lower byte of the current cycle.
    always_comb begin
        w_entry_u = '0;
        w_entry_l = '0;
        if (r_is_via) begin
            w_entry_u.via  = 1'b1;
            w_entry_u.data = cpuData[15:8];
        end else begin
            w_entry_u.bufSel = !cpuAddr[15];
            w_entry_u.addr   = {w_off, 1'b0};
            w_entry_u.data   = cpuData[15:8];
        end
        w_entry_l.bufSel = !cpuAddr[15];
        w_entry_l.addr   = {w_off, 1'b1};
        w_entry_l.data   = cpuData[7:0];
    end

    // Capture FSM state register; resets to WAIT_END.
    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            r_state <= WAIT_END;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture FSM next state, push request and overflow detection.
    always_comb begin
        w_state_nxt  = r_state;
        w_push       = 1'b0;
        w_push_entry = '0;
        w_set_ovf    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_as && (w_uds || w_lds)) begin
                    w_state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                if (w_fb_hit || w_via_hit) begin
                    if (w_room) begin
                        w_state_nxt = w_uds ? CAP_U : CAP_L;
                    end else begin
                        w_set_ovf   = 1'b1;
                        w_state_nxt = WAIT_END;
                    end
                end else begin
                    w_state_nxt = WAIT_END;
                end
            end
            CAP_U: begin
                w_push       = 1'b1;
                w_push_entry = w_entry_u;
                w_state_nxt  = r_want_l ? CAP_L : WAIT_END;
            end
            CAP_L: begin
                w_push       = 1'b1;
                w_push_entry = w_entry_l;
                w_state_nxt  = WAIT_END;
            end
            WAIT_END: begin
                if (!w_as) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = WAIT_END;
            end
        endcase
    end

    // Remember in DECIDE what the capture states must do for this cycle.
    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            r_want_l <= 1'b0;
            r_is_via <= 1'b0;
        end else if (r_state == DECIDE) begin
            r_want_l <= w_lds && !w_via_hit;
            r_is_via <= w_via_hit;
        end
    end

    // Sticky drop flag, cleared only by reset.
    always_ff @(posedge pixClk or negedge nReset) begin
        if (!nReset) begin
            r_overflow <= 1'b0;
        end else if (w_set_ovf) begin
            r_overflow <= 1'b1;
        end
    end

    assign w_pop = w_valid && wr.wrAck;

    sevga_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .pixClk  (pixClk),
        .nReset  (nReset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_level (w_level)
    );

    assign wr.wrValid  = w_valid;
    assign wr.wrBufSel = w_head.bufSel;
    assign wr.wrAddr   = w_head.addr;
    assign wr.wrData   = w_head.data;
    assign wr.wrVia    = w_head.via;

    assign level       = w_level;
    assign overflow    = r_overflow;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu_write_queue.sv
// tb_cpu_write_queue: directed bus writes with a scoreboard of expected VRAM
// entries; a monitor pops and compares each entry as it is drained.
module tb_cpu_write_queue;
    import sevga_pkg::*;

    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             nReset;
    logic             pixClk;
    logic [23:1]      cpuAddr;
    logic [15:0]      cpuData;
    logic             ncpuAS;
    logic             ncpuUDS;
    logic             ncpuLDS;
    logic             cpuRnW;
    logic [2:0]       ramSize;
    logic [LVL_W-1:0] level;
    logic             overflow;
    cap_state_t       dbg_state;

    cpu_write_queue_if wr_if();

    cpu_write_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .nReset      (nReset),
        .pixClk      (pixClk),
        .cpuAddr     (cpuAddr),
        .cpuData     (cpuData),
        .ncpuAS      (ncpuAS),
        .ncpuUDS     (ncpuUDS),
        .ncpuLDS     (ncpuLDS),
        .cpuRnW      (cpuRnW),
        .ramSize     (ramSize),
        .wr          (wr_if),
        .level       (level),
        .overflow    (overflow),
        .o_dbg_state (dbg_state)
    );

    int               n_checks = 0;
    int               n_errors = 0;
    logic [24:0]      exp_q[$];
    logic [24:0]      mon_got;
    logic [24:0]      mon_exp;
    logic             track_lvl = 1'b0;
    logic [LVL_W-1:0] max_lvl = '0;

    // Clock: 10 ns period.
    initial begin
        pixClk = 1'b0;
        forever #5 pixClk = ~pixClk;
    end

    function automatic logic [24:0] mk(input logic via, input logic bs,
                                       input logic [14:0] a, input logic [7:0] d);
        return {via, bs, a, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer (valid & ack before the edge) must match the queue head.
    always @(negedge pixClk) begin
        if (nReset === 1'b1 && wr_if.wrValid === 1'b1 && wr_if.wrAck === 1'b1) begin
            mon_got = {wr_if.wrVia, wr_if.wrBufSel, wr_if.wrAddr, wr_if.wrData};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_entry: got %0h, want none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("entry", 32'(mon_got), 32'(mon_exp));
            end
        end
        if (track_lvl && level > max_lvl) begin
            max_lvl = level;
        end
    end

    task automatic set_ack(input logic v);
        @(posedge pixClk);
        #1 wr_if.wrAck = v;
    endtask

    // One CPU bus cycle: strobes low for 'hold' clocks, then a 3-clock gap.
    task automatic bus_write(input logic [23:0] ba, input logic [15:0] d,
                             input logic u, input logic l, input logic rnw,
                             input int hold);
        cpuAddr = ba[23:1];
        cpuData = d;
        cpuRnW  = rnw;
        @(negedge pixClk);
        ncpuAS  = 1'b0;
        ncpuUDS = !u;
        ncpuLDS = !l;
        repeat (hold) @(negedge pixClk);
        ncpuAS  = 1'b1;
        ncpuUDS = 1'b1;
        ncpuLDS = 1'b1;
        repeat (3) @(negedge pixClk);
        cpuRnW  = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || level != '0) && i < 200) begin
            @(posedge pixClk);
            i++;
        end
        @(negedge pixClk);
        chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_level"}, 32'(level), 32'd0);
    endtask

    logic [23:0] b2b_addr [4] = '{24'h1FA710, 24'h1FA712, 24'h1FA714, 24'h1FA716};
    logic [14:0] b2b_vaddr[4] = '{15'h010, 15'h012, 15'h014, 15'h016};
    logic [15:0] b2b_data [4] = '{16'hC001, 16'hC102, 16'hC203, 16'hC304};

    initial begin
        int i;
        nReset       = 1'b0;
        cpuAddr      = '0;
        cpuData      = '0;
        ncpuAS       = 1'b1;
        ncpuUDS      = 1'b1;
        ncpuLDS      = 1'b1;
        cpuRnW       = 1'b1;
        ramSize      = 3'd3;
        wr_if.wrAck  = 1'b0;

        // Reset state.
        repeat (3) @(posedge pixClk);
        #1;
        chk("rst_valid",   32'(wr_if.wrValid),  32'd0);
        chk("rst_level",   32'(level),          32'd0);
        chk("rst_ovf",     32'(overflow),       32'd0);
        chk("rst_bufsel",  32'(wr_if.wrBufSel), 32'd0);
        chk("rst_addr",    32'(wr_if.wrAddr),   32'd0);
        chk("rst_data",    32'(wr_if.wrData),   32'd0);
        chk("rst_via",     32'(wr_if.wrVia),    32'd0);
        chk("rst_state",   32'(dbg_state),      32'(WAIT_END));
        @(negedge pixClk);
        nReset = 1'b1;
        repeat (4) @(negedge pixClk);
        set_ack(1'b1);

        // Word write at the first framebuffer word, main buffer.
        exp_q.push_back(mk(1'b0, 1'b0, 15'h0000, 8'hA5));
        exp_q.push_back(mk(1'b0, 1'b0, 15'h0001, 8'h5A));
        bus_write(24'h1FA700, 16'hA55A, 1'b1, 1'b1, 1'b0, 8);
        wait_drain("word");
        chk("word_ovf", 32'(overflow), 32'd0);

        // LDS-only write, alt buffer, offset 1.
        exp_q.push_back(mk(1'b0, 1'b1, 15'h0003, 8'hC3));
        bus_write(24'h1F2702, 16'h00C3, 1'b0, 1'b1, 1'b0, 8);
        wait_drain("lds_only");

        // Misses: below window, a read, wrong RAM size.
        bus_write(24'h1FA6FE, 16'h1234, 1'b1, 1'b1, 1'b0, 8);
        bus_write(24'h1FA700, 16'h1234, 1'b1, 1'b1, 1'b1, 8);
        ramSize = 3'd1;
        bus_write(24'h1FA700, 16'h1234, 1'b1, 1'b1, 1'b0, 8);
        ramSize = 3'd3;
        repeat (4) @(negedge pixClk);
        chk("miss_level", 32'(level), 32'd0);
        chk("miss_valid", 32'(wr_if.wrValid), 32'd0);

        // Back-to-back word writes with wrAck held high.
        max_lvl   = '0;
        track_lvl = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(1'b0, 1'b0, b2b_vaddr[k], b2b_data[k][15:8]));
            exp_q.push_back(mk(1'b0, 1'b0, b2b_vaddr[k] + 15'h1, b2b_data[k][7:0]));
            bus_write(b2b_addr[k], b2b_data[k], 1'b1, 1'b1, 1'b0, 8);
        end
        wait_drain("b2b");
        track_lvl = 1'b0;
        chk("b2b_max_level_le1", 32'(max_lvl <= LVL_W'(1)), 32'd1);
        chk("b2b_ovf", 32'(overflow), 32'd0);

        // Fill with wrAck low: third write is dropped.
        set_ack(1'b0);
        exp_q.push_back(mk(1'b0, 1'b0, 15'h0000, 8'h11));
        exp_q.push_back(mk(1'b0, 1'b0, 15'h0001, 8'h22));
        exp_q.push_back(mk(1'b0, 1'b0, 15'h0002, 8'h33));
        exp_q.push_back(mk(1'b0, 1'b0, 15'h0003, 8'h44));
        bus_write(24'h1FA700, 16'h1122, 1'b1, 1'b1, 1'b0, 8);
        bus_write(24'h1FA702, 16'h3344, 1'b1, 1'b1, 1'b0, 8);
        bus_write(24'h1FA704, 16'h5566, 1'b1, 1'b1, 1'b0, 8);
        chk("full_level", 32'(level), 32'd4);
        chk("full_ovf", 32'(overflow), 32'd1);
        set_ack(1'b1);
        wait_drain("full");
        chk("full_ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a word capture.
        set_ack(1'b0);
        cpuAddr = 23'h0FD380;
        cpuData = 16'hDEAD;
        cpuRnW  = 1'b0;
        @(negedge pixClk);
        ncpuAS  = 1'b0;
        ncpuUDS = 1'b0;
        ncpuLDS = 1'b0;
        i = 0;
        while (dbg_state != CAP_L && i < 40) begin
            @(negedge pixClk);
            i++;
        end
        chk("midrst_reached_cap_l", 32'(dbg_state == CAP_L), 32'd1);
        nReset = 1'b0;
        #1;
        chk("midrst_valid", 32'(wr_if.wrValid), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        repeat (2) @(negedge pixClk);
        nReset = 1'b1;
        repeat (6) @(negedge pixClk);
        chk("midrst_no_lower_level", 32'(level), 32'd0);
        chk("midrst_no_lower_valid", 32'(wr_if.wrValid), 32'd0);
        ncpuAS  = 1'b1;
        ncpuUDS = 1'b1;
        ncpuLDS = 1'b1;
        cpuRnW  = 1'b1;
        repeat (4) @(negedge pixClk);
        set_ack(1'b1);
        exp_q.push_back(mk(1'b0, 1'b0, 15'h0002, 8'h77));
        exp_q.push_back(mk(1'b0, 1'b0, 15'h0003, 8'h88));
        bus_write(24'h1FA702, 16'h7788, 1'b1, 1'b1, 1'b0, 8);
        wait_drain("after_rst");

        // VIA ORA write.
`ifdef SEVGA_VIA_CAPTURE_EN
        exp_q.push_back(mk(1'b1, 1'b0, 15'h0000, 8'h40));
`endif
        bus_write(24'hEFFFFE, 16'h40AB, 1'b1, 1'b0, 1'b0, 8);
        wait_drain("via");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1, "timeout");
    end

endmodule
